// File: rtl/dmem_access_unit.sv
// Data-memory access unit: aligns one load/store onto a req/ack bus,
// stalls the pipe while open, and returns sign/zero-extended load data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid, addr, wdata   request from execute stage
//   dmemwe, LD_sel           store byte mask / load type encoding
//   stall                    hold upstream pipeline
//   done, rdata_valid, rdata completion pulse and load result
//   misalign, err            fault pulses (illegal/misaligned, timeout)
//   bus_req .. bus_wdata     data-memory bus request fields
//   bus_ack, bus_rdata       data-memory bus response
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  dmemwe,
    input  logic [3:0]  LD_sel,
    output logic        stall,
    output logic        done,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [3:0]       ld_sel_q;

    logic        st_ok;
    logic        ld_ok;
    logic        is_half;
    logic        is_word;
    logic        mis;
    logic [31:0] shifted;
    logic [31:0] ext;

    // Request legality and alignment, evaluated on the live inputs in IDLE.
    always_comb begin
        st_ok = (LD_sel == 4'b0000) &&
                ((dmemwe == 4'b0001) || (dmemwe == 4'b0011) ||
                 (dmemwe == 4'b1111));
        ld_ok = (dmemwe == 4'b0000) &&
                ((LD_sel == 4'b0001) || (LD_sel == 4'b0011) ||
                 (LD_sel == 4'b1111) || (LD_sel == 4'b0101) ||
                 (LD_sel == 4'b0111));
        is_half = st_ok ? (dmemwe == 4'b0011)
                        : ((LD_sel == 4'b0011) || (LD_sel == 4'b0111));
        is_word = st_ok ? (dmemwe == 4'b1111) : (LD_sel == 4'b1111);
        mis = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    end

    // Load extraction from the returned word, using the captured offset.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        unique case (ld_sel_q)
            4'b0001: ext = {{24{shifted[7]}}, shifted[7:0]};
            4'b0101: ext = {24'b0, shifted[7:0]};
            4'b0011: ext = {{16{shifted[15]}}, shifted[15:0]};
            4'b0111: ext = {16'b0, shifted[15:0]};
            default: ext = bus_rdata;
        endcase
    end

    assign stall = ((state == IDLE) && req_valid) || (state == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            off_q       <= 2'b00;
            ld_sel_q    <= 4'b0000;
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= 32'h0;
            misalign    <= 1'b0;
            err         <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'b0000;
            bus_wdata   <= 32'h0;
        end else begin
            // Completion flags are single-cycle pulses.
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q    <= addr[1:0];
                        ld_sel_q <= LD_sel;
                        cnt      <= '0;
                        if ((st_ok || ld_ok) && !mis) begin
                            state     <= ISSUE;
                            bus_req   <= 1'b1;
                            bus_we    <= st_ok;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= st_ok ? (dmemwe << addr[1:0]) : 4'b0000;
                            bus_wdata <= wdata << {addr[1:0], 3'b000};
                        end else begin
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus_ack || (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'h0;
                        bus_be    <= 4'b0000;
                        bus_wdata <= 32'h0;
                        if (!bus_ack) begin
                            err <= 1'b1;
                        end else if (!bus_we) begin
                            rdata       <= ext;
                            rdata_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit.
// A second instance with a short timeout exercises the bus-timeout path.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_valid_t;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  dmemwe;
    logic [3:0]  LD_sel;
    logic        bus_ack;
    logic        bus_ack_t;
    logic [31:0] bus_rdata;

    logic        stall, done, rdata_valid, misalign, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        t_stall, t_done, t_rdata_valid, t_misalign, t_err;
    logic [31:0] t_rdata;
    logic        t_bus_req, t_bus_we;
    logic [31:0] t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .addr(addr),
        .wdata(wdata), .dmemwe(dmemwe), .LD_sel(LD_sel), .stall(stall),
        .done(done), .rdata_valid(rdata_valid), .rdata(rdata),
        .misalign(misalign), .err(err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    dmem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid_t), .addr(addr),
        .wdata(wdata), .dmemwe(dmemwe), .LD_sel(LD_sel), .stall(t_stall),
        .done(t_done), .rdata_valid(t_rdata_valid), .rdata(t_rdata),
        .misalign(t_misalign), .err(t_err), .bus_req(t_bus_req),
        .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be),
        .bus_wdata(t_bus_wdata), .bus_ack(bus_ack_t), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] we, input logic [3:0] ld);
        req_valid = 1'b1;
        addr      = a;
        wdata     = d;
        dmemwe    = we;
        LD_sel    = ld;
    endtask

    // Load with ack in the first ISSUE cycle; result checked in the DONE cycle.
    task automatic do_load(input string tag, input logic [31:0] a,
                           input logic [3:0] ld, input logic [31:0] rd,
                           input logic [31:0] exp);
        req(a, 32'h0, 4'b0000, ld);
        tick;
        req_valid = 1'b0;
        chk({tag, "_req"}, {31'b0, bus_req}, 32'd1);
        chk({tag, "_be"}, {28'b0, bus_be}, 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        tick;
        bus_ack = 1'b0;
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_rv"}, {31'b0, rdata_valid}, 32'd1);
        chk({tag, "_rdata"}, rdata, exp);
        tick;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_valid_t = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        dmemwe = 4'b0000;
        LD_sel = 4'b0000;
        bus_ack = 1'b0;
        bus_ack_t = 1'b0;
        bus_rdata = 32'h0;
        tick;
        tick;
        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        rst = 1'b0;
        tick;

        // SB at offset 3, ack in cycle 1
        req(32'h0000_1003, 32'h0000_00A5, 4'b0001, 4'b0000);
        #1;
        chk("sb_stall0", {31'b0, stall}, 32'd1);
        tick;
        req_valid = 1'b0;
        chk("sb_req", {31'b0, bus_req}, 32'd1);
        chk("sb_we", {31'b0, bus_we}, 32'd1);
        chk("sb_be", {28'b0, bus_be}, 32'h8);
        chk("sb_wdata", bus_wdata, 32'hA500_0000);
        chk("sb_addr", bus_addr, 32'h0000_1000);
        chk("sb_stall1", {31'b0, stall}, 32'd1);
        bus_ack = 1'b1;
        tick;
        bus_ack = 1'b0;
        chk("sb_done", {31'b0, done}, 32'd1);
        chk("sb_rv", {31'b0, rdata_valid}, 32'd0);
        chk("sb_req2", {31'b0, bus_req}, 32'd0);
        chk("sb_stall2", {31'b0, stall}, 32'd0);
        tick;
        chk("sb_done3", {31'b0, done}, 32'd0);

        // Load extraction
        do_load("lb", 32'h0000_2001, 4'b0001, 32'h0000_8000, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_2001, 4'b0101, 32'h0000_8000, 32'h0000_0080);
        do_load("lh", 32'h0000_2002, 4'b0011, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu", 32'h0000_2002, 4'b0111, 32'h8001_0000, 32'h0000_8001);
        do_load("lb3", 32'h0000_2003, 4'b0001, 32'h7F00_0000, 32'h0000_007F);
        do_load("lw", 32'h0000_2004, 4'b1111, 32'h1234_5678, 32'h1234_5678);

        // Misaligned LW
        req(32'h0000_3002, 32'h0, 4'b0000, 4'b1111);
        #1;
        chk("mis_stall0", {31'b0, stall}, 32'd1);
        tick;
        req_valid = 1'b0;
        chk("mis_done", {31'b0, done}, 32'd1);
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_err", {31'b0, err}, 32'd0);
        chk("mis_rv", {31'b0, rdata_valid}, 32'd0);
        chk("mis_req", {31'b0, bus_req}, 32'd0);
        chk("mis_stall1", {31'b0, stall}, 32'd0);
        tick;
        chk("mis_req2", {31'b0, bus_req}, 32'd0);
        chk("mis_done2", {31'b0, done}, 32'd0);

        // Illegal store mask
        req(32'h0000_3000, 32'h0, 4'b0101, 4'b0000);
        tick;
        req_valid = 1'b0;
        chk("ill_done", {31'b0, done}, 32'd1);
        chk("ill_flag", {31'b0, misalign}, 32'd1);
        chk("ill_req", {31'b0, bus_req}, 32'd0);
        tick;

        // Misaligned SH
        req(32'h0000_3001, 32'h0, 4'b0011, 4'b0000);
        tick;
        req_valid = 1'b0;
        chk("sh_mis", {31'b0, misalign}, 32'd1);
        tick;

        // SW with ack in the 5th ISSUE cycle
        req(32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            tick;
            req_valid = 1'b0;
            chk($sformatf("sw_req%0d", i), {31'b0, bus_req}, 32'd1);
            chk($sformatf("sw_addr%0d", i), bus_addr, 32'h0000_4000);
            chk($sformatf("sw_wd%0d", i), bus_wdata, 32'hDEAD_BEEF);
            chk($sformatf("sw_be%0d", i), {28'b0, bus_be}, 32'hF);
            chk($sformatf("sw_stall%0d", i), {31'b0, stall}, 32'd1);
            chk($sformatf("sw_done%0d", i), {31'b0, done}, 32'd0);
            if (i == 5) bus_ack = 1'b1;
        end
        tick;
        bus_ack = 1'b0;
        chk("sw_done", {31'b0, done}, 32'd1);
        chk("sw_err", {31'b0, err}, 32'd0);
        chk("sw_req_off", {31'b0, bus_req}, 32'd0);
        chk("sw_rdata_kept", rdata, 32'h1234_5678);
        tick;

        // Timeout on the short-timeout instance
        addr = 32'h0000_5000;
        dmemwe = 4'b0000;
        LD_sel = 4'b1111;
        req_valid_t = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            req_valid_t = 1'b0;
            chk($sformatf("to_req%0d", i), {31'b0, t_bus_req}, 32'd1);
            chk($sformatf("to_done%0d", i), {31'b0, t_done}, 32'd0);
        end
        tick;
        chk("to_done", {31'b0, t_done}, 32'd1);
        chk("to_err", {31'b0, t_err}, 32'd1);
        chk("to_req_off", {31'b0, t_bus_req}, 32'd0);
        chk("to_rv", {31'b0, t_rdata_valid}, 32'd0);
        tick;
        chk("to_done_off", {31'b0, t_done}, 32'd0);

        // Reset in the second ISSUE cycle
        req(32'h0000_6000, 32'h0, 4'b0000, 4'b1111);
        tick;
        req_valid = 1'b0;
        tick;
        chk("rr_req", {31'b0, bus_req}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rr_req0", {31'b0, bus_req}, 32'd0);
        chk("rr_done0", {31'b0, done}, 32'd0);
        chk("rr_stall0", {31'b0, stall}, 32'd0);
        chk("rr_rdata0", rdata, 32'h0);
        chk("rr_addr0", bus_addr, 32'h0);
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        tick;
        bus_ack = 1'b0;
        chk("rr_late_done", {31'b0, done}, 32'd0);
        chk("rr_late_rv", {31'b0, rdata_valid}, 32'd0);
        chk("rr_late_req", {31'b0, bus_req}, 32'd0);
        do_load("rr_lw", 32'h0000_6004, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
